alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter_pkg.sv | 26 ++
 rtl/alu_share_arbiter_alu.sv | 33 +++
 rtl/alu_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter slice.
//   - FSM state type (IDLE / EXEC / RESP)
//   - operand, op-code and completion-counter widths
//   - op-code assignments understood by alu_8bit
package alu_share_arbiter_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [OP_W-1:0] ALU_SHL = 4'h5;
  localparam logic [OP_W-1:0] ALU_SHR = 4'h6;
  localparam logic [OP_W-1:0] ALU_NOT = 4'h7;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// alu_8bit: purely combinational 8-bit ALU shared by all requesters.
// Ports:
//   a, b      : 8-bit operands
//   op        : 4-bit operation code (unassigned codes give result 0, carry 0)
//   result    : 8-bit result
//   carry_out : carry for ADD/SHL/SHR, borrow for SUB, 0 otherwise
module alu_8bit
  import alu_share_arbiter_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [OPND_W-1:0] result,
  output logic              carry_out
);

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    case (op)
      ALU_ADD: {carry_out, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: {carry_out, result} = {1'b0, a} - {1'b0, b};
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: {carry_out, result} = {a, 1'b0};
      ALU_SHR: {result, carry_out} = {1'b0, a};
      ALU_NOT: result = ~a;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter giving NREQ requesters access to one
// alu_8bit. One operation at a time: accept (IDLE), evaluate (EXEC), present
// the response until consumed (RESP).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b, req_op  : per-requester operand / op-code slices
//   rsp_valid / rsp_ready : response handshake
//   rsp_id, rsp_result, rsp_carry : response payload
//   busy                  : high outside IDLE
//   op_count              : saturating count of consumed responses
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OPND_W*NREQ-1:0] req_a,
  input  logic [OPND_W*NREQ-1:0] req_b,
  input  logic [OP_W*NREQ-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [OPND_W-1:0]      rsp_result,
  output logic                   rsp_carry,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      last_grant_q, last_grant_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [OPND_W-1:0]   opa_q, opa_d;
  logic [OPND_W-1:0]   opb_q, opb_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [OPND_W-1:0]   res_q, res_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDW-1:0]      gnt_idx;
  logic                gnt_any;
  logic [IDW-1:0]      cand;
  logic [OPND_W-1:0]   alu_res;
  logic                alu_carry;

  alu_8bit u_alu (
    .a         (opa_q),
    .b         (opb_q),
    .op        (op_q),
    .result    (alu_res),
    .carry_out (alu_carry)
  );

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    res_d        = res_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    req_ready    = '0;

    case (state_q)
      ST_IDLE: begin
        // Ready is gated by rst_n so it reads zero throughout reset.
        if (gnt_any && rst_n) begin
          req_ready    = NREQ'(1) << gnt_idx;
          state_d      = ST_EXEC;
          last_grant_d = gnt_idx;
          id_d         = gnt_idx;
          opa_d        = req_a[32'(gnt_idx)*OPND_W +: OPND_W];
          opb_d        = req_b[32'(gnt_idx)*OPND_W +: OPND_W];
          op_d         = req_op[32'(gnt_idx)*OP_W +: OP_W];
        end
      end
      ST_EXEC: begin
        res_d   = alu_res;
        carry_d = alu_carry;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_carry  = carry_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [4*NREQ-1:0] req_op = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_result;
  logic              rsp_carry;
  logic              busy;
  logic [15:0]       op_count;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic; returns {carry, result}.
  function automatic logic [8:0] alu_ref(input int a, input int b, input int op);
    int r;
    bit c;
    r = 0;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (r < 0); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; c = (a >= 128); end
      6: begin r = a / 2; c = ((a % 2) == 1); end
      7: r = 255 - a;
      default: r = 0;
    endcase
    r = ((r % 256) + 256) % 256;
    return {c, 8'(r)};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Transaction-level model: an accepted request yields its response two
  // edges later; it stays visible until consumed.
  bit         m_busy = 1'b0;
  bit         m_shown = 1'b0;
  int         m_last = NREQ - 1;
  int         m_id = 0;
  logic [8:0] m_exp = '0;
  int         m_count = 0;
  int         m_pick;

  always_comb m_pick = rr_pick(req_valid, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_shown <= 1'b0;
      m_last  <= NREQ - 1;
      m_count <= 0;
    end else if (!m_busy) begin
      if (m_pick >= 0) begin
        m_busy  <= 1'b1;
        m_shown <= 1'b0;
        m_last  <= m_pick;
        m_id    <= m_pick;
        m_exp   <= alu_ref(req_a[m_pick*8 +: 8], req_b[m_pick*8 +: 8], req_op[m_pick*4 +: 4]);
      end
    end else if (!m_shown) begin
      m_shown <= 1'b1;
    end else if (rsp_ready) begin
      m_busy  <= 1'b0;
      if (m_count < 65535) m_count <= m_count + 1;
    end
  end

  int dut_grants[$];
  bit seen_id2 = 1'b0;
  int completions = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    exp_ready = '0;
    if (rst_n && !m_busy && m_pick >= 0) exp_ready[m_pick] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, rst_n && m_busy && m_shown);
    chk("busy", busy, rst_n && m_busy);
    chk("op_count", op_count, m_count);
    if (rst_n && m_busy && m_shown) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_exp[7:0]);
      chk("rsp_carry", rsp_carry, m_exp[8]);
    end
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
    if (rsp_valid && rsp_id == 2) seen_id2 = 1'b1;
    if (!rst_n) completions = 0;
    else if (rsp_valid && rsp_ready) completions++;
  end

  task automatic set_req(input int i, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op);
    req_valid[i]     = v;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*4 +: 4] = op;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for requester i's handshake, then drops its valid.
  task automatic wait_hs(input int i);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) got = 1'b1;
    end
    chk($sformatf("handshake_req%0d", i), got, 1'b1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic rand_step(input bit allow_new);
    logic [NREQ-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] || !req_valid[i]) begin
        set_req(i, allow_new && ($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom),
                4'($urandom_range(0, 15)));
      end else if (allow_new && $urandom_range(0, 19) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = !allow_new || ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no finish, required finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Pin the reference ALU with hand-computed values.
    chk("ref_add_33_cc", alu_ref(8'h33, 8'hCC, 0), 9'h0FF);
    chk("ref_add_f0_20", alu_ref(8'hF0, 8'h20, 0), 9'h110);
    chk("ref_sub_10_20", alu_ref(8'h10, 8'h20, 1), 9'h1F0);
    chk("ref_shl_81", alu_ref(8'h81, 8'h00, 5), 9'h102);
    chk("ref_shr_03", alu_ref(8'h03, 8'h00, 6), 9'h101);

    // Reset state with every requester valid.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'h5A, 8'hA5, 4'h2);
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 4'b0000);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_result", rsp_result, 8'h00);
    chk("reset_rsp_carry", rsp_carry, 1'b0);
    chk("reset_rsp_id", rsp_id, 2'd0);
    chk("reset_op_count", op_count, 16'd0);

    // Single request, grant in the first cycle after release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = '0;
    set_req(0, 1'b1, 8'h33, 8'hCC, 4'h0);
    @(negedge clk);
    chk("t1_first_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_exec_no_rsp", rsp_valid, 1'b0);
    chk("t1_exec_busy", busy, 1'b1);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_id", rsp_id, 2'd0);
    chk("t1_rsp_result", rsp_result, 8'hFF);
    chk("t1_rsp_carry", rsp_carry, 1'b0);
    @(negedge clk);
    chk("t1_op_count", op_count, 16'd1);
    chk("t1_idle", rsp_valid, 1'b0);

    // All four requesting: 0,1,2,3,0,... ; 8 responses in 24 cycles.
    do_reset();
    dut_grants.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(16 * i + 5), 8'(8'h30 + i), 4'(i));
    tick(24);
    req_valid = '0;
    chk("rr_op_count_24cyc", op_count, 16'd8);
    chk("rr_grant_count", dut_grants.size(), 8);
    for (int g = 0; g < 8; g++)
      chk($sformatf("rr_grant_%0d", g), (g < dut_grants.size()) ? dut_grants[g] : -1, g % NREQ);

    // Backpressure: response held for 5 cycles with rsp_ready low.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 8'hF0, 8'h20, 4'h0);
    set_req(1, 1'b1, 8'h5A, 8'h0F, 4'h4);
    wait_hs(0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_result", rsp_result, 8'h10);
      chk("bp_rsp_carry", rsp_carry, 1'b1);
      chk("bp_rsp_id", rsp_id, 2'd0);
      chk("bp_req_ready", req_ready, 4'b0000);
      chk("bp_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_hold", rsp_valid, 1'b1);
    @(negedge clk);
    chk("bp_released", rsp_valid, 1'b0);
    chk("bp_op_count", op_count, 16'd1);
    chk("bp_next_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    tick(4);

    // Reset while in EXEC discards the operation.
    do_reset();
    set_req(0, 1'b1, 8'h11, 8'h22, 4'h0);
    wait_hs(0);
    #2 rst_n = 1'b0;
    dut_grants.delete();
    @(negedge clk);
    chk("rexec_rsp_valid", rsp_valid, 1'b0);
    chk("rexec_op_count", op_count, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(0, 1'b1, 8'h44, 8'h01, 4'h1);
    set_req(1, 1'b1, 8'h0F, 8'hF0, 4'h3);
    wait_hs(0);
    chk("rexec_first_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);
    wait_hs(1);
    tick(4);
    chk("rexec_op_count_after", op_count, 16'd2);

    // Requester 2 withdraws before being granted.
    do_reset();
    seen_id2 = 1'b0;
    set_req(0, 1'b1, 8'h01, 8'h02, 4'h0);
    set_req(1, 1'b1, 8'h03, 8'h04, 4'h1);
    set_req(2, 1'b1, 8'h05, 8'h06, 4'h2);
    wait_hs(0);
    req_valid[2] = 1'b0;
    wait_hs(1);
    tick(8);
    chk("withdraw_no_id2", seen_id2, 1'b0);
    chk("withdraw_op_count", op_count, 16'd2);

    // Random traffic with random backpressure.
    do_reset();
    for (int cyc = 0; cyc < 20000 && completions < 1000; cyc++) rand_step(1'b1);
    for (int cyc = 0; cyc < 40; cyc++) rand_step(1'b0);
    @(negedge clk);
    chk("rand_ops_done", completions >= 1000, 1'b1);
    chk("rand_op_count", op_count, completions);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
